// File: rtl/irq_ack_decoder.sv
// irq_ack_decoder
//   Takes a group-level request (pa/pb/pc plus an encoded channel) and turns
//   it into a CPU interrupt with vector group*9+chan. When the CPU accepts
//   the interrupt, the block returns a one-cycle one-hot clear pulse to the
//   source that raised it. After the pulse, it waits in HOLD until the source
//   withdraws its request.
//
//   Optional feature: define IRQ_ACK_TIMEOUT_EN to add the ISSUE watchdog.
//   The watchdog is an 8-bit cycle counter and a sticky tmo output. Without
//   the macro, ISSUE waits for cpu_ack indefinitely and the tmo port does not
//   exist.
module irq_ack_decoder #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       pa,
  input  logic       pb,
  input  logic       pc,
  input  logic [3:0] chan,
  input  logic       req_valid,
  input  logic       cpu_ack,
  output logic       irq,
  output logic [4:0] vec,
  output logic [8:0] ack_a,
  output logic [8:0] ack_b,
  output logic [8:0] ack_c,
  output logic       busy,
  output logic       err
`ifdef IRQ_ACK_TIMEOUT_EN
  ,
  output logic       tmo
`endif
);

  // Group codes double as the multiplier in the vector arithmetic.
  localparam logic [1:0] GRP_A = 2'd0;
  localparam logic [1:0] GRP_B = 2'd1;
  localparam logic [1:0] GRP_C = 2'd2;

  // A TIMEOUT outside 1..255 cannot be represented by the 8-bit watchdog.
  // Such a build never accepts a request, so it fails visibly instead of
  // issuing interrupts with a broken timeout.
  localparam bit TIMEOUT_OK = (TIMEOUT >= 1) && (TIMEOUT <= 255);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ACK   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e     state_q;
  logic [1:0] grp_q;
  logic [3:0] chan_q;
  logic       irq_q;
  logic [4:0] vec_q;
  logic [8:0] ack_a_q;
  logic [8:0] ack_b_q;
  logic [8:0] ack_c_q;
  logic       busy_q;
  logic       err_q;
`ifdef IRQ_ACK_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       tmo_q;
`endif

  logic [1:0] grp_d;
  logic       capture_d;
  logic       chan_legal_d;
  logic [4:0] vec_d;
  logic [8:0] ack_onehot_d;
  logic       hold_flag_d;

  // Request qualification, priority pick, vector arithmetic and ack decode.
  always_comb begin
    grp_d        = GRP_C;
    capture_d    = 1'b0;
    chan_legal_d = 1'b0;
    vec_d        = 5'd0;
    ack_onehot_d = 9'd0;
    hold_flag_d  = 1'b0;

    if (pa) begin
      grp_d = GRP_A;
    end else if (pb) begin
      grp_d = GRP_B;
    end

    capture_d    = req_valid && (pa || pb || pc) && TIMEOUT_OK;
    chan_legal_d = (chan <= 4'd8);
    vec_d        = ({3'b000, grp_d} * 5'd9) + {1'b0, chan};

    // chan_q only ever holds a legal code (0..8), so the shift stays in range.
    ack_onehot_d = 9'd1 << chan_q;

    case (grp_q)
      GRP_A:   hold_flag_d = pa;
      GRP_B:   hold_flag_d = pb;
      default: hold_flag_d = pc;
    endcase
  end

  // Control FSM; every output is registered alongside the state transition.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      grp_q   <= GRP_A;
      chan_q  <= 4'd0;
      irq_q   <= 1'b0;
      vec_q   <= 5'd0;
      ack_a_q <= 9'd0;
      ack_b_q <= 9'd0;
      ack_c_q <= 9'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      // The ack outputs are single-cycle pulses by default.
      ack_a_q <= 9'd0;
      ack_b_q <= 9'd0;
      ack_c_q <= 9'd0;

      case (state_q)
        S_IDLE: begin
          if (capture_d) begin
            if (chan_legal_d) begin
              // vec is loaded only on a legal capture, so it never leaves
              // the 0..26 range.
              grp_q   <= grp_d;
              chan_q  <= chan;
              vec_q   <= vec_d;
              irq_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= S_ISSUE;
`ifdef IRQ_ACK_TIMEOUT_EN
              cnt_q   <= 8'd0;
`endif
            end else begin
              err_q   <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (cpu_ack) begin
            // cpu_ack takes precedence over a timeout in the same cycle.
            irq_q   <= 1'b0;
            state_q <= S_ACK;
            case (grp_q)
              GRP_A:   ack_a_q <= ack_onehot_d;
              GRP_B:   ack_b_q <= ack_onehot_d;
              default: ack_c_q <= ack_onehot_d;
            endcase
`ifdef IRQ_ACK_TIMEOUT_EN
          end else if (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT)) begin
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
`endif
          end
        end

        S_ACK: begin
          state_q <= S_HOLD;
        end

        S_HOLD: begin
          // The return to IDLE takes one edge, so a new capture always needs
          // at least one IDLE cycle first.
          if (!req_valid || !hold_flag_d) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign irq   = irq_q;
  assign vec   = vec_q;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign ack_c = ack_c_q;
  assign busy  = busy_q;
  assign err   = err_q;
`ifdef IRQ_ACK_TIMEOUT_EN
  assign tmo   = tmo_q;
`endif

endmodule

// File: tb/tb_irq_ack_decoder.sv
// Testbench for irq_ack_decoder: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_irq_ack_decoder;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       pa = 1'b0;
  logic       pb = 1'b0;
  logic       pc = 1'b0;
  logic [3:0] chan = 4'd0;
  logic       req_valid = 1'b0;
  logic       cpu_ack = 1'b0;
  logic       irq;
  logic [4:0] vec;
  logic [8:0] ack_a;
  logic [8:0] ack_b;
  logic [8:0] ack_c;
  logic       busy;
  logic       err;
`ifdef IRQ_ACK_TIMEOUT_EN
  logic       tmo;
  localparam int TMO = 4;

  irq_ack_decoder #(.TIMEOUT(TMO)) dut (
    .CK(CK), .RST(RST), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
    .req_valid(req_valid), .cpu_ack(cpu_ack), .irq(irq), .vec(vec),
    .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c), .busy(busy), .err(err),
    .tmo(tmo)
  );
`else
  irq_ack_decoder dut (
    .CK(CK), .RST(RST), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
    .req_valid(req_valid), .cpu_ack(cpu_ack), .irq(irq), .vec(vec),
    .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c), .busy(busy), .err(err)
  );
`endif

  always #5 CK = ~CK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model. It tracks the transaction phase, not a register image.
  // The three ack ports are treated as one 27-bit word in which the pulse
  // sits at bit position vec.
  int          mp;       // 0 idle, 1 waiting for cpu, 2 ack pulse, 3 waiting for release
  int          m_grp;
  int          m_vec;
  int          m_cnt;
  bit          m_err;
  bit          m_tmo;
  logic [26:0] m_ack;

  task automatic model_reset();
    mp = 0; m_grp = 0; m_vec = 0; m_cnt = 0;
    m_err = 1'b0; m_tmo = 1'b0; m_ack = '0;
  endtask

  task automatic model_step();
    int  g;
    bit  flag;
    if (RST) begin
      model_reset();
    end else begin
      m_ack = '0;
      if (mp == 0) begin
        if (req_valid && (pa || pb || pc)) begin
          g = pa ? 0 : (pb ? 1 : 2);
          if (int'(chan) <= 8) begin
            m_grp = g;
            m_vec = g * 9 + int'(chan);
            m_cnt = 0;
            mp    = 1;
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (mp == 1) begin
        if (cpu_ack) begin
          mp    = 2;
          m_ack = 27'd1 << m_vec;
        end else begin
`ifdef IRQ_ACK_TIMEOUT_EN
          m_cnt = m_cnt + 1;
          if (m_cnt == TMO) begin
            mp    = 0;
            m_tmo = 1'b1;
          end
`endif
        end
      end else if (mp == 2) begin
        mp = 3;
      end else begin
        flag = (m_grp == 0) ? pa : ((m_grp == 1) ? pb : pc);
        if (!req_valid || !flag) mp = 0;
      end
    end
  endtask

  // Advance one clock. The model sees the same pre-edge inputs as the DUT.
  task automatic tick();
    model_step();
    @(posedge CK);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " irq"},  32'(irq),  32'(mp == 1));
    chk({tag, " busy"}, 32'(busy), 32'(mp != 0));
    chk({tag, " err"},  32'(err),  32'(m_err));
    chk({tag, " vec"},  32'(vec),  32'(m_vec));
    chk({tag, " ack"},  32'({ack_c, ack_b, ack_a}), 32'(m_ack));
`ifdef IRQ_ACK_TIMEOUT_EN
    chk({tag, " tmo"},  32'(tmo),  32'(m_tmo));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " irq"},  32'(irq),  32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " err"},  32'(err),  32'd0);
    chk({tag, " vec"},  32'(vec),  32'd0);
    chk({tag, " ack"},  32'({ack_c, ack_b, ack_a}), 32'd0);
`ifdef IRQ_ACK_TIMEOUT_EN
    chk({tag, " tmo"},  32'(tmo),  32'd0);
`endif
  endtask

  typedef struct {
    logic       pa, pb, pc;
    logic [3:0] chan;
    logic       legal;
    logic [4:0] vec;
    logic [8:0] a, b, c;
    logic       err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd3,  1'b1, 5'd12, 9'b0, 9'b000001000, 9'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 4'd8,  1'b1, 5'd8,  9'b100000000, 9'b0, 9'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 5'd18, 9'b0, 9'b0, 9'b000000001, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 4'd8,  1'b1, 5'd17, 9'b0, 9'b100000000, 9'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 5'd0,  9'b000000001, 9'b0, 9'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 4'd8,  1'b1, 5'd26, 9'b0, 9'b0, 9'b100000000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 5'd5,  9'b000100000, 9'b0, 9'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 4'd11, 1'b0, 5'd5,  9'b0, 9'b0, 9'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 4'd2,  1'b1, 5'd11, 9'b0, 9'b000000100, 9'b0, 1'b1};

    model_reset();

    // Reset state.
    RST = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();
    RST = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      pa = tbl[i].pa; pb = tbl[i].pb; pc = tbl[i].pc; chan = tbl[i].chan;
      req_valid = 1'b1; cpu_ack = 1'b0;
      tick();
      chk($sformatf("tbl%0d irq", i),  32'(irq),  32'(tbl[i].legal));
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].legal));
      chk($sformatf("tbl%0d vec", i),  32'(vec),  32'(tbl[i].vec));
      chk($sformatf("tbl%0d err", i),  32'(err),  32'(tbl[i].err));
      if (tbl[i].legal) begin
        // Garbage on the request inputs must be ignored outside IDLE.
        pa = 1'b1; pb = 1'b1; pc = 1'b1; chan = 4'hF; req_valid = 1'b0;
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        chk($sformatf("tbl%0d ack_a", i), 32'(ack_a), 32'(tbl[i].a));
        chk($sformatf("tbl%0d ack_b", i), 32'(ack_b), 32'(tbl[i].b));
        chk($sformatf("tbl%0d ack_c", i), 32'(ack_c), 32'(tbl[i].c));
        chk($sformatf("tbl%0d irq_off", i), 32'(irq), 32'd0);
        chk($sformatf("tbl%0d vec_held", i), 32'(vec), 32'(tbl[i].vec));
        tick();
        chk($sformatf("tbl%0d pulse_end", i), 32'({ack_c, ack_b, ack_a}), 32'd0);
        chk($sformatf("tbl%0d hold_busy", i), 32'(busy), 32'd1);
        pa = 1'b0; pb = 1'b0; pc = 1'b0;
        tick();
        chk($sformatf("tbl%0d idle", i), 32'(busy), 32'd0);
      end else begin
        req_valid = 1'b0;
        tick();
        chk($sformatf("tbl%0d stay_idle", i), 32'(busy), 32'd0);
        chk($sformatf("tbl%0d no_irq", i),    32'(irq),  32'd0);
      end
    end

    // HOLD persists while the request stays up, then re-arms.
    pa = 1'b1; pb = 1'b0; pc = 1'b0; chan = 4'd1; req_valid = 1'b1;
    tick();
    chk("hold irq", 32'(irq), 32'd1);
    chk("hold vec", 32'(vec), 32'd1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("hold ack_a", 32'(ack_a), 32'h002);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold busy", 32'(busy), 32'd1);
      chk("hold noirq", 32'(irq), 32'd0);
    end
    req_valid = 1'b0;
    tick();
    chk("hold release", 32'(busy), 32'd0);
    req_valid = 1'b1;
    tick();
    chk("hold reraise irq", 32'(irq), 32'd1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    tick();
    // Own group flag drops while B requests: back to IDLE, no capture yet.
    pa = 1'b0; pb = 1'b1; chan = 4'd6;
    tick();
    chk("hold flag drop busy", 32'(busy), 32'd0);
    chk("hold flag drop irq", 32'(irq), 32'd0);
    tick();
    chk("hold next irq", 32'(irq), 32'd1);
    chk("hold next vec", 32'(vec), 32'd15);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("hold next ack_b", 32'(ack_b), 32'h040);
    req_valid = 1'b0;
    tick();
    tick();
    chk("hold next idle", 32'(busy), 32'd0);

    // Asynchronous reset while in ISSUE.
    pb = 1'b0; pc = 1'b1; chan = 4'd4; req_valid = 1'b1;
    tick();
    chk("rst_issue irq", 32'(irq), 32'd1);
    req_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("rst_issue");
    cpu_ack = 1'b1;
    tick();
    chk("rst_issue no_ack", 32'({ack_c, ack_b, ack_a}), 32'd0);
    // First capture on the first edge after reset release.
    RST = 1'b0;
    cpu_ack = 1'b0; pa = 1'b1; pc = 1'b0; chan = 4'd2; req_valid = 1'b1;
    tick();
    chk("post_rst irq", 32'(irq), 32'd1);
    chk("post_rst vec", 32'(vec), 32'd2);
    req_valid = 1'b0;
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("rst_ack pulse", 32'(ack_a), 32'h004);
    // Reset during the ack pulse cuts it short immediately.
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst_ack cut", 32'({ack_c, ack_b, ack_a}), 32'd0);
    chk("rst_ack busy", 32'(busy), 32'd0);
    tick();
    RST = 1'b0;

`ifdef IRQ_ACK_TIMEOUT_EN
    // Watchdog expiry: no cpu_ack for TMO ISSUE cycles.
    pa = 1'b0; pb = 1'b1; chan = 4'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("tmo c1 irq", 32'(irq), 32'd1);
    for (int k = 2; k <= TMO; k++) begin
      tick();
      chk($sformatf("tmo c%0d irq", k), 32'(irq), 32'd1);
    end
    tick();
    chk("tmo expire irq", 32'(irq), 32'd0);
    chk("tmo expire busy", 32'(busy), 32'd0);
    chk("tmo expire flag", 32'(tmo), 32'd1);
    chk("tmo expire ack", 32'({ack_c, ack_b, ack_a}), 32'd0);
    tick();
    chk("tmo sticky", 32'(tmo), 32'd1);
    chk("tmo no_late_ack", 32'({ack_c, ack_b, ack_a}), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    // cpu_ack in the last allowed cycle wins over the timeout.
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 2; k <= TMO; k++) tick();
    chk("tmo race irq", 32'(irq), 32'd1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("tmo race ack_b", 32'(ack_b), 32'h001);
    chk("tmo race flag", 32'(tmo), 32'd0);
    tick();
    tick();
    chk("tmo race idle", 32'(busy), 32'd0);
`endif

    // Randomized run against the reference model.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      pa        = ($urandom_range(0, 3) == 0);
      pb        = ($urandom_range(0, 3) == 0);
      pc        = ($urandom_range(0, 2) == 0);
      chan      = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
      cpu_ack   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) begin
        RST = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
        tick();
        RST = 1'b0;
      end else begin
        tick();
        check_model("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
